// File: rtl/swerv_trace_pkg.sv
// Shared types for the SweRV retire-trace capture buffer.
package swerv_trace_pkg;

  localparam int TRACE_LANES = 2;

  // One captured retirement; {intr, exc} is what readout presents as rd_flags.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic        intr;
    logic        exc;
  } trace_entry_t;

endpackage

// File: rtl/swerv_trace_buffer.sv
// Retire-trace FIFO: compacts up to two retirements per cycle into a flop
// array, pops one entry per rd_req, and counts entries lost when full.
module swerv_trace_buffer
  import swerv_trace_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WRAP_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [63:0]                trace_rv_i_insn_ip,
  input  logic [63:0]                trace_rv_i_address_ip,
  input  logic [2:0]                 trace_rv_i_valid_ip,
  input  logic [2:0]                 trace_rv_i_exception_ip,
  input  logic [2:0]                 trace_rv_i_interrupt_ip,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [31:0]                rd_addr,
  output logic [31:0]                rd_insn,
  output logic [1:0]                 rd_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  trace_entry_t            mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q;

  trace_entry_t            lane_e [TRACE_LANES];
  logic [TRACE_LANES-1:0]  lane_v;
  trace_entry_t            wr_e0, wr_e1, rd_entry;
  logic [1:0]              n, acc, lost;
  logic [CW:0]             free;
  logic                    pop;
  logic [PW-1:0]           rd_adv;
  logic [CW-1:0]           count_nxt;
  logic [CNT_W:0]          drop_sum;

  // Bit 2 of the per-lane trace vectors belongs to a third lane this core never drives.
  logic unused_lane2;
  assign unused_lane2 = ^{trace_rv_i_valid_ip[2], trace_rv_i_exception_ip[2],
                          trace_rv_i_interrupt_ip[2]};

  // Unpack the trace port into per-lane entries gated by capture enable.
  always_comb begin
    for (int l = 0; l < TRACE_LANES; l++) begin
      lane_e[l] = '{addr: trace_rv_i_address_ip[32*l +: 32],
                    insn: trace_rv_i_insn_ip[32*l +: 32],
                    intr: trace_rv_i_interrupt_ip[l],
                    exc:  trace_rv_i_exception_ip[l]};
      lane_v[l] = enable & trace_rv_i_valid_ip[l];
    end
  end

  // Lane0 is older; a lone lane1 retirement slides into the first write port.
  assign wr_e0 = lane_v[0] ? lane_e[0] : lane_e[1];
  assign wr_e1 = lane_e[1];
  assign n     = {1'b0, lane_v[0]} + {1'b0, lane_v[1]};

  assign pop  = rd_req & (count_q != '0);
  // A same-cycle pop frees its slot; it always reads the pre-write contents.
  assign free = DEPTH_C - {1'b0, count_q} + (CW+1)'(pop);

  // Decide how many entries land and how many are lost on overflow.
  always_comb begin
    acc  = n;
    lost = 2'd0;
    if ((CW+1)'(n) > free) begin
      lost = n - free[1:0];
      if (WRAP_MODE == 0) acc = free[1:0];
    end
  end

  // In wrap mode the oldest entries are discarded by pushing rd_ptr past them.
  assign rd_adv    = PW'(pop) + ((WRAP_MODE != 0) ? PW'(lost) : '0);
  assign count_nxt = count_q + CW'(acc) - CW'(pop) - ((WRAP_MODE != 0) ? CW'(lost) : '0);
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(lost);
  assign rd_entry  = mem[rd_ptr];

  // Pointer, occupancy and drop-counter state; clear outranks push and pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(acc);
      rd_ptr   <= rd_ptr + rd_adv;
      count_q  <= count_nxt;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  // Storage array: two write ports at wr_ptr and wr_ptr+1, no reset needed.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (acc != 2'd0) mem[wr_ptr]          <= wr_e0;
      if (acc == 2'd2) mem[wr_ptr + PW'(1)] <= wr_e1;
    end
  end

  // Registered readout; data holds between pops, valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      rd_insn  <= '0;
      rd_flags <= '0;
    end else begin
      rd_valid <= pop & ~clear;
      if (pop && !clear) begin
        rd_addr  <= rd_entry.addr;
        rd_insn  <= rd_entry.insn;
        rd_flags <= {rd_entry.intr, rd_entry.exc};
      end
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_swerv_trace_buffer.sv
// Scoreboard bench: three buffer configurations driven by directed vectors.
module tb_swerv_trace_buffer;

  typedef struct packed {
    logic [63:0] insn;
    logic [63:0] addr;
    logic [2:0]  valid;
    logic [2:0]  exc;
    logic [2:0]  intr;
    logic        enable;
    logic        clear;
    logic        rd_req;
  } drv_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic [1:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  drv_t        drv [3];
  logic        rdv [3];
  logic [31:0] rda [3];
  logic [31:0] rdi [3];
  logic [1:0]  rdf [3];
  logic        full [3];
  logic        empty [3];
  logic [6:0]  cnt0;
  logic [2:0]  cnt1, cnt2;
  logic [15:0] dc0, dc1;
  logic [1:0]  dc2;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int failures = 0;

  swerv_trace_buffer u0 (
    .clk(clk), .rst_l(rst_l),
    .trace_rv_i_insn_ip(drv[0].insn), .trace_rv_i_address_ip(drv[0].addr),
    .trace_rv_i_valid_ip(drv[0].valid), .trace_rv_i_exception_ip(drv[0].exc),
    .trace_rv_i_interrupt_ip(drv[0].intr), .enable(drv[0].enable),
    .clear(drv[0].clear), .rd_req(drv[0].rd_req),
    .rd_valid(rdv[0]), .rd_addr(rda[0]), .rd_insn(rdi[0]), .rd_flags(rdf[0]),
    .count(cnt0), .full(full[0]), .empty(empty[0]), .drop_cnt(dc0));

  swerv_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) u1 (
    .clk(clk), .rst_l(rst_l),
    .trace_rv_i_insn_ip(drv[1].insn), .trace_rv_i_address_ip(drv[1].addr),
    .trace_rv_i_valid_ip(drv[1].valid), .trace_rv_i_exception_ip(drv[1].exc),
    .trace_rv_i_interrupt_ip(drv[1].intr), .enable(drv[1].enable),
    .clear(drv[1].clear), .rd_req(drv[1].rd_req),
    .rd_valid(rdv[1]), .rd_addr(rda[1]), .rd_insn(rdi[1]), .rd_flags(rdf[1]),
    .count(cnt1), .full(full[1]), .empty(empty[1]), .drop_cnt(dc1));

  swerv_trace_buffer #(.DEPTH(4), .WRAP_MODE(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_l(rst_l),
    .trace_rv_i_insn_ip(drv[2].insn), .trace_rv_i_address_ip(drv[2].addr),
    .trace_rv_i_valid_ip(drv[2].valid), .trace_rv_i_exception_ip(drv[2].exc),
    .trace_rv_i_interrupt_ip(drv[2].intr), .enable(drv[2].enable),
    .clear(drv[2].clear), .rd_req(drv[2].rd_req),
    .rd_valid(rdv[2]), .rd_addr(rda[2]), .rd_insn(rdi[2]), .rd_flags(rdf[2]),
    .count(cnt2), .full(full[2]), .empty(empty[2]), .drop_cnt(dc2));

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_rd(input int id, input exp_t e);
    checks++;
    if ({rda[id], rdi[id], rdf[id]} !== e) begin
      failures++;
      $display("FAIL rd%0d: got addr=%h insn=%h flags=%b expected addr=%h insn=%h flags=%b",
               id, rda[id], rdi[id], rdf[id], e.addr, e.insn, e.flags);
    end
  endtask

  task automatic unexpected(input int id);
    checks++;
    failures++;
    $display("FAIL rd%0d_unexpected: got rd_valid=1 addr=%h expected no read", id, rda[id]);
  endtask

  // Monitors: pop the expected entry whenever a DUT presents rd_valid.
  always @(negedge clk) if (rst_l && rdv[0]) begin
    if (q0.size() == 0) unexpected(0); else chk_rd(0, q0.pop_front());
  end
  always @(negedge clk) if (rst_l && rdv[1]) begin
    if (q1.size() == 0) unexpected(1); else chk_rd(1, q1.pop_front());
  end
  always @(negedge clk) if (rst_l && rdv[2]) begin
    if (q2.size() == 0) unexpected(2); else chk_rd(2, q2.pop_front());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [2:0] v, input logic [31:0] pc0,
                      input logic [31:0] pc1, input logic [2:0] exc = 3'b0,
                      input logic [2:0] intr = 3'b0);
    drv[id].valid = v;
    drv[id].addr  = {pc1, pc0};
    drv[id].insn  = {ins(pc1), ins(pc0)};
    drv[id].exc   = exc;
    drv[id].intr  = intr;
    cyc();
    drv[id].valid = 3'b0;
    drv[id].exc   = 3'b0;
    drv[id].intr  = 3'b0;
  endtask

  task automatic expect_rd(input int id, input logic [31:0] pc, input logic [1:0] fl);
    exp_t e;
    e = '{addr: pc, insn: ins(pc), flags: fl};
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic rd(input int id, input logic [31:0] pc, input logic [1:0] fl);
    expect_rd(id, pc, fl);
    drv[id].rd_req = 1'b1;
    cyc();
    drv[id].rd_req = 1'b0;
  endtask

  task automatic pulse_clear(input int id);
    drv[id].clear = 1'b1;
    cyc();
    drv[id].clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      drv[i] = '0;
      drv[i].enable = 1'b1;
    end
    rst_l = 1'b0;
    cyc(); cyc();
    chk("reset_count", cnt0, 0);
    chk("reset_empty", empty[0], 1);
    chk("reset_full", full[0], 0);
    chk("reset_drop", dc0, 0);
    rst_l = 1'b1;
    cyc();

    // Reset in the middle of traffic, while a read pulse is in flight.
    push(0, 3'b011, 32'h10, 32'h14);
    push(0, 3'b011, 32'h18, 32'h1C);
    push(0, 3'b001, 32'h20, 32'h0);
    chk("pre_reset_count", cnt0, 5);
    rd(0, 32'h10, 2'b00);
    @(negedge clk); #1;
    rst_l = 1'b0;
    #1;
    chk("midreset_count", cnt0, 0);
    chk("midreset_empty", empty[0], 1);
    chk("midreset_drop", dc0, 0);
    chk("midreset_rdv", rdv[0], 0);
    chk("midreset_rdaddr", rda[0], 0);
    cyc();
    rst_l = 1'b1;
    cyc();

    // Dual retire; lane0 also flags an interrupt.
    push(0, 3'b011, 32'h100, 32'h104, 3'b000, 3'b001);
    chk("dual_count", cnt0, 2);
    rd(0, 32'h100, 2'b10);
    rd(0, 32'h104, 2'b00);
    chk("dual_drained", cnt0, 0);
    chk("dual_empty", empty[0], 1);
    // A read request on an empty buffer must not pulse, and data holds.
    drv[0].rd_req = 1'b1;
    cyc();
    drv[0].rd_req = 1'b0;
    cyc();
    chk("empty_rd_rdv", rdv[0], 0);
    chk("empty_rd_hold", rda[0], 32'h104);

    // Valid bit 2 is ignored; then lane1-only retirement compacts into one entry.
    push(0, 3'b100, 32'h300, 32'h304);
    chk("lane2_ignored", cnt0, 0);
    push(0, 3'b010, 32'hDEAD, 32'h200, 3'b010, 3'b000);
    chk("lane1_count", cnt0, 1);
    rd(0, 32'h200, 2'b01);

    // DEPTH=4 drop-when-full.
    push(1, 3'b011, 32'h0, 32'h4);
    push(1, 3'b011, 32'h8, 32'hC);
    push(1, 3'b011, 32'h10, 32'h14);
    chk("stop_count", cnt1, 4);
    chk("stop_full", full[1], 1);
    chk("stop_drop", dc1, 2);
    rd(1, 32'h0, 2'b00);
    rd(1, 32'h4, 2'b00);
    rd(1, 32'h8, 2'b00);
    rd(1, 32'hC, 2'b00);
    chk("stop_drained", cnt1, 0);
    drv[1].enable = 1'b0;
    push(1, 3'b011, 32'h60, 32'h64);
    chk("disabled_count", cnt1, 0);
    drv[1].enable = 1'b1;

    // DEPTH=4 wrap (keep newest), 2-bit saturating drop counter.
    push(2, 3'b011, 32'h0, 32'h4);
    push(2, 3'b011, 32'h8, 32'hC);
    push(2, 3'b011, 32'h10, 32'h14);
    chk("wrap_count", cnt2, 4);
    chk("wrap_full", full[2], 1);
    chk("wrap_drop", dc2, 2);
    rd(2, 32'h8, 2'b00);
    rd(2, 32'hC, 2'b00);
    rd(2, 32'h10, 2'b00);
    rd(2, 32'h14, 2'b00);
    push(2, 3'b011, 32'h20, 32'h24);
    push(2, 3'b011, 32'h28, 32'h2C);
    push(2, 3'b011, 32'h30, 32'h34);
    chk("wrap_drop_sat", dc2, 3);
    chk("wrap_count2", cnt2, 4);
    rd(2, 32'h28, 2'b00);
    pulse_clear(2);
    chk("wrap_clear_count", cnt2, 0);
    chk("wrap_clear_drop", dc2, 0);

    // Same-cycle pop frees a slot for a dual push at count=DEPTH-1.
    pulse_clear(1);
    chk("clear_drop", dc1, 0);
    push(1, 3'b011, 32'h40, 32'h44);
    push(1, 3'b001, 32'h48, 32'h0);
    chk("near_full_count", cnt1, 3);
    expect_rd(1, 32'h40, 2'b00);
    drv[1].rd_req = 1'b1;
    push(1, 3'b011, 32'h4C, 32'h50);
    drv[1].rd_req = 1'b0;
    chk("pushpop_count", cnt1, 4);
    chk("pushpop_drop", dc1, 0);
    chk("pushpop_full", full[1], 1);
    // Clear wins over a simultaneous push and pop.
    drv[1].clear  = 1'b1;
    drv[1].rd_req = 1'b1;
    push(1, 3'b011, 32'h54, 32'h58);
    drv[1].clear  = 1'b0;
    drv[1].rd_req = 1'b0;
    chk("clearpush_count", cnt1, 0);
    chk("clearpush_drop", dc1, 0);
    chk("clearpush_empty", empty[1], 1);
    chk("clearpush_rdv", rdv[1], 0);
    chk("clearpush_hold", rda[1], 32'h40);

    repeat (3) cyc();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
